// File: rtl/sfx_beat_sequencer_pkg.sv
// Shared definitions for the sound-effect beat sequencer and the tone ROM.
// Keeping the beat table here means the ROM contents and the sequencer
// always agree on where each effect lives and where silence is.
package sfx_beat_sequencer_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Effect identifiers (also the bit positions in the request vector)
    localparam logic SFX_GOAL = 1'b0;
    localparam logic SFX_HIT  = 1'b1;

    // Beat index parked on while silent; the ROM default entry must be silence here
    localparam logic [7:0] SFX_IDLE_BEAT = 8'd255;

    // Default beat rate: 0.25 s per beat at 100 MHz
    localparam int DEF_BEAT_DIV = 25_000_000;

    // Default ROM layout: first beat and length of each effect
    localparam logic [7:0] DEF_BASE0 = 8'd0;
    localparam logic [7:0] DEF_LEN0  = 8'd2;
    localparam logic [7:0] DEF_BASE1 = 8'd16;
    localparam logic [7:0] DEF_LEN1  = 8'd1;

    // Fixed-priority arbitration: goal always wins over hit
    function automatic logic arb_pick(input logic [1:0] pend);
        return pend[SFX_GOAL] ? SFX_GOAL : SFX_HIT;
    endfunction

endpackage

// File: rtl/sfx_beat_sequencer_beat_tick.sv
// Beat-rate divider: counts 0..BEAT_DIV-1 and pulses tick on the terminal
// count. clear forces the count back to zero so a fresh effect always gets
// a full-length first beat.
module sfx_beat_sequencer_beat_tick #(
    parameter int BEAT_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = $clog2(BEAT_DIV);
    localparam logic [CW-1:0]   TERM = CW'(BEAT_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Next count: restart on clear or terminal count, otherwise increment
    always_comb begin
        cnt_next = cnt_reg;
        if (clear || (cnt_reg == TERM)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = !clear && (cnt_reg == TERM);

endmodule

// File: rtl/sfx_beat_sequencer.sv
// Sound-effect beat sequencer: arbitrates goal/hit requests, steps the tone
// ROM beat index at a fixed rate, and parks on a silent index when idle.
module sfx_beat_sequencer
    import sfx_beat_sequencer_pkg::*;
#(
    parameter int         BEAT_DIV  = DEF_BEAT_DIV,
    parameter logic [7:0] BASE0     = DEF_BASE0,
    parameter logic [7:0] LEN0      = DEF_LEN0,
    parameter logic [7:0] BASE1     = DEF_BASE1,
    parameter logic [7:0] LEN1      = DEF_LEN1,
    parameter logic [7:0] IDLE_BEAT = SFX_IDLE_BEAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       abort,
    output logic [7:0] beatnum,
    output logic       playing,
    output logic       grant,
    output logic       done
);

    // Per-effect ROM table, indexed by effect id
    logic [7:0] eff_base [2];
    logic [7:0] eff_len  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tbl
            assign eff_base[gi] = (gi == 0) ? BASE0 : BASE1;
            assign eff_len[gi]  = (gi == 0) ? LEN0  : LEN1;
        end
    endgenerate

    seq_state_t state_reg,   state_next;
    logic [1:0] pending_reg, pending_next;
    logic [7:0] idx_reg,     idx_next;
    logic [7:0] beatnum_reg, beatnum_next;
    logic       playing_reg, playing_next;
    logic       grant_reg,   grant_next;
    logic       done_reg,    done_next;

    logic [1:0] pend_sampled;
    logic       grant_sel;
    logic       tick;
    logic       tick_clear;

    // A request arriving in IDLE is seen the same cycle, so it starts next cycle
    assign pend_sampled = pending_reg | req;
    assign grant_sel    = arb_pick(pend_sampled);

    // Divider only runs while an effect plays; it restarts from zero on entry
    assign tick_clear = abort || (state_reg != ST_PLAY);

    sfx_beat_sequencer_beat_tick #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Next-state, arbitration and registered-output computation
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg | req;
        idx_next     = idx_reg;
        beatnum_next = beatnum_reg;
        playing_next = playing_reg;
        grant_next   = grant_reg;
        done_next    = 1'b0;

        if (abort) begin
            // Abort wins over everything, including a same-cycle request
            state_next   = ST_IDLE;
            pending_next = 2'b00;
            beatnum_next = IDLE_BEAT;
            playing_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|pend_sampled) begin
                        state_next              = ST_PLAY;
                        grant_next              = grant_sel;
                        pending_next[grant_sel] = 1'b0;
                        idx_next                = 8'd0;
                        beatnum_next            = eff_base[grant_sel];
                        playing_next            = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (idx_reg == (eff_len[grant_reg] - 8'd1)) begin
                            state_next   = ST_DONE;
                            beatnum_next = IDLE_BEAT;
                            playing_next = 1'b0;
                            done_next    = 1'b1;
                        end else begin
                            idx_next     = idx_reg + 8'd1;
                            beatnum_next = eff_base[grant_reg] + idx_reg + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // One silent cycle with done high, then re-arbitrate from IDLE
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next   = ST_IDLE;
                    beatnum_next = IDLE_BEAT;
                    playing_next = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pending_reg <= 2'b00;
            idx_reg     <= 8'd0;
            beatnum_reg <= IDLE_BEAT;
            playing_reg <= 1'b0;
            grant_reg   <= SFX_GOAL;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            idx_reg     <= idx_next;
            beatnum_reg <= beatnum_next;
            playing_reg <= playing_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
        end
    end

    assign beatnum = beatnum_reg;
    assign playing = playing_reg;
    assign grant   = grant_reg;
    assign done    = done_reg;

endmodule
